// File: rtl/intersection_pkg.sv
// Shared state codes, lamp codes and duration lookup for the intersection controller.
package intersection_pkg;

    localparam logic [2:0] AR_EW = 3'd0;
    localparam logic [2:0] NS_G  = 3'd1;
    localparam logic [2:0] NS_Y  = 3'd2;
    localparam logic [2:0] AR_NS = 3'd3;
    localparam logic [2:0] EW_G  = 3'd4;
    localparam logic [2:0] EW_Y  = 3'd5;

    // Lamp head encoding: {green, yellow, red}
    localparam logic [2:0] LAMP_GREEN  = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_RED    = 3'b001;

    function automatic logic [2:0] next_state(input logic [2:0] s);
        case (s)
            AR_EW:   next_state = NS_G;
            NS_G:    next_state = NS_Y;
            NS_Y:    next_state = AR_NS;
            AR_NS:   next_state = EW_G;
            EW_G:    next_state = EW_Y;
            default: next_state = AR_EW;
        endcase
    endfunction

    function automatic int state_dur(input logic [2:0] s, input int g,
                                     input int y, input int ar);
        case (s)
            NS_G, EW_G: state_dur = g;
            NS_Y, EW_Y: state_dur = y;
            default:    state_dur = ar;
        endcase
    endfunction

    function automatic logic [2:0] ns_lamp(input logic [2:0] s);
        case (s)
            NS_G:    ns_lamp = LAMP_GREEN;
            NS_Y:    ns_lamp = LAMP_YELLOW;
            default: ns_lamp = LAMP_RED;
        endcase
    endfunction

    function automatic logic [2:0] ew_lamp(input logic [2:0] s);
        case (s)
            EW_G:    ew_lamp = LAMP_GREEN;
            EW_Y:    ew_lamp = LAMP_YELLOW;
            default: ew_lamp = LAMP_RED;
        endcase
    endfunction

endpackage

// File: rtl/intersection_sequencer_sec_tick_gen.sv
// Seconds timebase: one-cycle tick every TICK_DIV clk cycles.
module sec_tick_gen #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int DW = $clog2(TICK_DIV);

    logic [DW-1:0] cnt;

    assign tick = (cnt == DW'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/intersection_sequencer.sv
// Two-way intersection sequencer with all-red clearance and pedestrian walk.
// Optional walk/ack logic is built when PED_WALK_EN is defined.
module intersection_sequencer
    import intersection_pkg::*;
#(
    parameter int TICK_DIV = 100_000_000,
    parameter int GREEN_S  = 25,
    parameter int YELLOW_S = 5,
    parameter int ALLRED_S = 2,
    parameter int WALK_S   = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ped_req_ns,
    input  logic       ped_req_ew,
    output logic       ns_green,
    output logic       ns_yellow,
    output logic       ns_red,
    output logic       ew_green,
    output logic       ew_yellow,
    output logic       ew_red,
    output logic       walk_ns,
    output logic       walk_ew,
    output logic       ped_ack_ns,
    output logic       ped_ack_ew,
    output logic [2:0] phase
);

    localparam int MAX_GY = (GREEN_S > YELLOW_S) ? GREEN_S : YELLOW_S;
    localparam int MAX_D  = (MAX_GY > ALLRED_S) ? MAX_GY : ALLRED_S;
    localparam int CW     = (MAX_D > 1) ? $clog2(MAX_D) : 1;

    logic          tick;
    logic          advance;
    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic [CW-1:0] sec_cnt;

    sec_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    assign advance   = tick && (sec_cnt == '0);
    assign state_nxt = advance ? next_state(state) : state;
    assign phase     = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= AR_EW;
            sec_cnt <= CW'(ALLRED_S - 1);
        end else if (advance) begin
            state   <= state_nxt;
            sec_cnt <= CW'(state_dur(state_nxt, GREEN_S,
                                     YELLOW_S, ALLRED_S) - 1);
        end else if (tick) begin
            sec_cnt <= sec_cnt - 1'b1;
        end
    end

    // Lamps are registered from the next state so they move with phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {ns_green, ns_yellow, ns_red} <= LAMP_RED;
            {ew_green, ew_yellow, ew_red} <= LAMP_RED;
        end else begin
            {ns_green, ns_yellow, ns_red} <= ns_lamp(state_nxt);
            {ew_green, ew_yellow, ew_red} <= ew_lamp(state_nxt);
        end
    end

`ifdef PED_WALK_EN
    logic          pend_ns;
    logic          pend_ew;
    logic          serve_ns;
    logic          serve_ew;
    logic [CW-1:0] walk_cnt;

    assign serve_ns = advance && (state_nxt == NS_G)
                      && (pend_ns || ped_req_ns);
    assign serve_ew = advance && (state_nxt == EW_G)
                      && (pend_ew || ped_req_ew);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_ns    <= 1'b0;
            pend_ew    <= 1'b0;
            ped_ack_ns <= 1'b0;
            ped_ack_ew <= 1'b0;
            walk_ns    <= 1'b0;
            walk_ew    <= 1'b0;
            walk_cnt   <= '0;
        end else begin
            ped_ack_ns <= serve_ns;
            ped_ack_ew <= serve_ew;
            pend_ns    <= serve_ns ? 1'b0 : (pend_ns | ped_req_ns);
            pend_ew    <= serve_ew ? 1'b0 : (pend_ew | ped_req_ew);
            // Only one green can be active, so one walk timer suffices.
            if (serve_ns || serve_ew) begin
                walk_ns  <= serve_ns;
                walk_ew  <= serve_ew;
                walk_cnt <= CW'(WALK_S - 1);
            end else if (advance) begin
                walk_ns <= 1'b0;
                walk_ew <= 1'b0;
            end else if (tick && (walk_ns || walk_ew)) begin
                if (walk_cnt == '0) begin
                    walk_ns <= 1'b0;
                    walk_ew <= 1'b0;
                end else begin
                    walk_cnt <= walk_cnt - 1'b1;
                end
            end
        end
    end
`else
    logic unused_ped;
    assign unused_ped = ^{ped_req_ns, ped_req_ew, WALK_S[0]};
    assign walk_ns    = 1'b0;
    assign walk_ew    = 1'b0;
    assign ped_ack_ns = 1'b0;
    assign ped_ack_ew = 1'b0;
`endif

endmodule

// File: tb/tb_intersection_sequencer.sv
// Self-checking bench: per-cycle comparison against a time-position model.
module tb_intersection_sequencer;

    localparam int TD   = 4;
    localparam int G    = 3;
    localparam int Y    = 2;
    localparam int AR   = 1;
    localparam int W    = 2;
    localparam int C_AR = AR * TD;
    localparam int C_G  = G * TD;
    localparam int C_Y  = Y * TD;
    localparam int PER  = 2 * (C_AR + C_G + C_Y);
    localparam int NS_IN = C_AR;
    localparam int EW_IN = 2 * C_AR + C_G + C_Y;

    logic       clk = 1'b0;
    logic       reset;
    logic       ped_req_ns;
    logic       ped_req_ew;
    logic       ns_green, ns_yellow, ns_red;
    logic       ew_green, ew_yellow, ew_red;
    logic       walk_ns, walk_ew;
    logic       ped_ack_ns, ped_ack_ew;
    logic [2:0] phase;

    int n_cmp = 0;
    int n_bad = 0;
    int t;
`ifdef PED_WALK_EN
    bit pend_ns, pend_ew;
    int walk_end_ns, walk_end_ew;
`endif

    intersection_sequencer #(
        .TICK_DIV (TD),
        .GREEN_S  (G),
        .YELLOW_S (Y),
        .ALLRED_S (AR),
        .WALK_S   (W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ped_req_ns (ped_req_ns),
        .ped_req_ew (ped_req_ew),
        .ns_green   (ns_green),
        .ns_yellow  (ns_yellow),
        .ns_red     (ns_red),
        .ew_green   (ew_green),
        .ew_yellow  (ew_yellow),
        .ew_red     (ew_red),
        .walk_ns    (walk_ns),
        .walk_ew    (walk_ew),
        .ped_ack_ns (ped_ack_ns),
        .ped_ack_ew (ped_ack_ew),
        .phase      (phase)
    );

    always #5 clk = ~clk;

    function automatic int phase_of(input int p);
        if (p < C_AR)                        return 0;
        if (p < C_AR + C_G)                  return 1;
        if (p < C_AR + C_G + C_Y)            return 2;
        if (p < 2 * C_AR + C_G + C_Y)        return 3;
        if (p < 2 * C_AR + 2 * C_G + C_Y)    return 4;
        return 5;
    endfunction

    function automatic logic [12:0] observed();
        return {ns_green, ns_yellow, ns_red, ew_green, ew_yellow, ew_red,
                walk_ns, walk_ew, ped_ack_ns, ped_ack_ew, phase};
    endfunction

    task automatic model_reset();
        t = 0;
`ifdef PED_WALK_EN
        pend_ns = 0;
        pend_ew = 0;
        walk_end_ns = 0;
        walk_end_ew = 0;
`endif
    endtask

    task automatic check_reset_vals(input string tag);
        n_cmp++;
        assert (observed() === 13'b001_001_0000_000) else begin
            n_bad++;
            $error("FAIL %s got=%b want=%b", tag, observed(),
                   13'b001_001_0000_000);
        end
    endtask

    // Check the current cycle, then drive requests sampled at its closing edge.
    task automatic step(input bit rn, input bit re);
        int p;
        int ph;
        bit an, ae, wn, we;
        logic [12:0] expv;
        p  = t % PER;
        ph = phase_of(p);
        an = 0; ae = 0; wn = 0; we = 0;
`ifdef PED_WALK_EN
        if (p == NS_IN && pend_ns) begin
            an = 1;
            pend_ns = 0;
            walk_end_ns = t + W * TD;
        end
        if (p == EW_IN && pend_ew) begin
            ae = 1;
            pend_ew = 0;
            walk_end_ew = t + W * TD;
        end
        wn = (t < walk_end_ns);
        we = (t < walk_end_ew);
`endif
        expv = {ph == 1, ph == 2, !(ph == 1 || ph == 2),
                ph == 4, ph == 5, !(ph == 4 || ph == 5),
                wn, we, an, ae, 3'(ph)};
        n_cmp++;
        assert (observed() === expv) else begin
            n_bad++;
            $error("FAIL cycle t=%0d got=%b want=%b", t, observed(), expv);
        end
        n_cmp++;
        assert ($onehot({ns_green, ns_yellow, ns_red})
                && $onehot({ew_green, ew_yellow, ew_red})
                && !(ns_green && ew_green)) else begin
            n_bad++;
            $error("FAIL lamp_onehot t=%0d got=%b want=onehot", t,
                   observed());
        end
        ped_req_ns = rn;
        ped_req_ew = re;
`ifdef PED_WALK_EN
        pend_ns = pend_ns | rn;
        pend_ew = pend_ew | re;
`endif
        @(posedge clk);
        t++;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        ped_req_ns = 1'b0;
        ped_req_ew = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_vals("reset_state");
        reset = 1'b0;

        repeat (2 * PER) step(0, 0);
        repeat (PER) step(0, (t % PER) == 8);
        repeat (2 * PER) step((t % PER) >= NS_IN && (t % PER) < NS_IN + C_G, 0);
        repeat (PER) step((t % PER) == 25, (t % PER) == 25);
        repeat (PER) step(0, 0);
        repeat (5 * PER) step($urandom_range(0, 11) == 0,
                              $urandom_range(0, 11) == 0);

        while ((t % PER) != 0) step(0, 0);
        while ((t % PER) != 32) step(0, (t % PER) == 10);
        #2 reset = 1'b1;
        #1 check_reset_vals("mid_ew_reset");
        @(negedge clk);
        check_reset_vals("held_reset");
        reset = 1'b0;
        model_reset();
        repeat (2 * PER) step($urandom_range(0, 7) == 0,
                              $urandom_range(0, 7) == 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
